// File: rtl/alu_decode_stage.sv
// ---------------------------------------------------------------------------
// alu_decode_stage
//   Decode stage between fetch and execute for RV32I. Each accepted word is
//   decoded into an ALU opcode, register indices, a sign-extended immediate
//   and control flags. Output is a 2-deep elastic buffer (main + skid) so the
//   stage sustains one word per cycle while in_ready stays a flop output.
//
//   Ports
//     clk, rst_n          clock / async active-low reset
//     flush               drop every buffered entry (branch redirect)
//     in_valid/in_ready   fetch handshake (in_ready registered)
//     in_instr, in_pc     instruction word and its pc
//     out_valid/out_ready execute handshake
//     out_pc .. illegal   decoded bundle, driven straight from the main entry
//
//   ALU opcode encoding (ALUInstr):
//     ADD=0 SUB=1 SLL=2 SRL=3 SRA=4 OR=5 AND=6 XOR=7 SLT=8 ULT=9 UGTE=10
//     EQ=11 SGTE=12
//   On an illegal word: alu_op=ADD, imm=0, every control flag 0, illegal=1.
//   Register fields keep their raw values unless ILLEGAL_AS_NOP=1, in which
//   case they are zeroed too (ADD x0,x0,0).
// ---------------------------------------------------------------------------
module alu_decode_stage #(
  parameter int PC_W           = 32,
  parameter bit ILLEGAL_AS_NOP = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [3:0]      alu_op,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [31:0]     imm,
  output logic            use_imm,
  output logic            use_pc,
  output logic            reg_we,
  output logic            is_branch,
  output logic            br_invert,
  output logic            is_load,
  output logic            is_store,
  output logic            is_jump,
  output logic            illegal
);

  localparam logic [3:0] A_ADD  = 4'd0,  A_SUB = 4'd1,  A_SLL = 4'd2,
                         A_SRL  = 4'd3,  A_SRA = 4'd4,  A_OR  = 4'd5,
                         A_AND  = 4'd6,  A_XOR = 4'd7,  A_SLT = 4'd8,
                         A_ULT  = 4'd9,  A_UGTE = 4'd10, A_EQ = 4'd11,
                         A_SGTE = 4'd12;

  localparam logic [6:0] OPC_OP     = 7'b0110011,
                         OPC_OPIMM  = 7'b0010011,
                         OPC_LUI    = 7'b0110111,
                         OPC_AUIPC  = 7'b0010111,
                         OPC_LOAD   = 7'b0000011,
                         OPC_STORE  = 7'b0100011,
                         OPC_BRANCH = 7'b1100011,
                         OPC_JAL    = 7'b1101111,
                         OPC_JALR   = 7'b1100111;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [3:0]      alu_op;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [31:0]     imm;
    logic            use_imm;
    logic            use_pc;
    logic            reg_we;
    logic            is_branch;
    logic            br_invert;
    logic            is_load;
    logic            is_store;
    logic            is_jump;
    logic            illegal;
  } bundle_t;

  // ---------------- decode ----------------
  bundle_t     dec;
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [3:0]  f3_op;
  logic        ill;

  assign opc   = in_instr[6:0];
  assign f3    = in_instr[14:12];
  assign f7    = in_instr[31:25];
  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                  in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u = {in_instr[31:12], 12'h000};
  assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                  in_instr[20], in_instr[30:21], 1'b0};

  // funct3 -> ALU op shared by OP and OP-IMM (funct7 refinement applied later)
  always_comb begin
    f3_op = A_ADD;
    case (f3)
      3'b000: f3_op = A_ADD;
      3'b001: f3_op = A_SLL;
      3'b010: f3_op = A_SLT;
      3'b011: f3_op = A_ULT;
      3'b100: f3_op = A_XOR;
      3'b101: f3_op = A_SRL;
      3'b110: f3_op = A_OR;
      default: f3_op = A_AND;
    endcase
  end

  always_comb begin
    dec        = '0;
    dec.pc     = in_pc;
    dec.rs1    = in_instr[19:15];
    dec.rs2    = in_instr[24:20];
    dec.rd     = in_instr[11:7];
    dec.alu_op = A_ADD;
    ill        = 1'b0;
    case (opc)
      OPC_OP: begin
        dec.reg_we = 1'b1;
        dec.alu_op = f3_op;
        if (f7 == 7'h20 && f3 == 3'b000)      dec.alu_op = A_SUB;
        else if (f7 == 7'h20 && f3 == 3'b101) dec.alu_op = A_SRA;
        else if (f7 != 7'h00)                 ill = 1'b1;
      end
      OPC_OPIMM: begin
        dec.reg_we  = 1'b1;
        dec.use_imm = 1'b1;
        dec.alu_op  = f3_op;
        dec.imm     = imm_i;
        // shifts carry shamt in [24:20]; funct7 must be 0, or 0x20 for SRAI
        if (f3 == 3'b001 || f3 == 3'b101) begin
          dec.imm = {27'd0, in_instr[24:20]};
          if (f3 == 3'b101 && f7 == 7'h20) dec.alu_op = A_SRA;
          else if (f7 != 7'h00)            ill = 1'b1;
        end
      end
      OPC_LUI: begin
        dec.rs1     = 5'd0;
        dec.use_imm = 1'b1;
        dec.imm     = imm_u;
        dec.reg_we  = 1'b1;
      end
      OPC_AUIPC: begin
        dec.use_pc  = 1'b1;
        dec.use_imm = 1'b1;
        dec.imm     = imm_u;
        dec.reg_we  = 1'b1;
      end
      OPC_LOAD: begin
        dec.use_imm = 1'b1;
        dec.imm     = imm_i;
        dec.is_load = 1'b1;
        dec.reg_we  = 1'b1;
        ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_STORE: begin
        dec.use_imm  = 1'b1;
        dec.imm      = imm_s;
        dec.is_store = 1'b1;
        ill = (f3 > 3'b010);
      end
      OPC_BRANCH: begin
        dec.is_branch = 1'b1;
        dec.imm       = imm_b;
        case (f3)
          3'b000: dec.alu_op = A_EQ;
          3'b001: begin dec.alu_op = A_EQ; dec.br_invert = 1'b1; end
          3'b100: dec.alu_op = A_SLT;
          3'b101: dec.alu_op = A_SGTE;
          3'b110: dec.alu_op = A_ULT;
          3'b111: dec.alu_op = A_UGTE;
          default: ill = 1'b1;
        endcase
      end
      OPC_JAL: begin
        dec.use_pc  = 1'b1;
        dec.use_imm = 1'b1;
        dec.is_jump = 1'b1;
        dec.imm     = imm_j;
        dec.reg_we  = 1'b1;
      end
      OPC_JALR: begin
        dec.use_imm = 1'b1;
        dec.is_jump = 1'b1;
        dec.imm     = imm_i;
        dec.reg_we  = 1'b1;
        ill = (f3 != 3'b000);
      end
      default: ill = 1'b1;
    endcase

    if (ill) begin
      dec.alu_op    = A_ADD;
      dec.imm       = '0;
      dec.use_imm   = 1'b0;
      dec.use_pc    = 1'b0;
      dec.reg_we    = 1'b0;
      dec.is_branch = 1'b0;
      dec.br_invert = 1'b0;
      dec.is_load   = 1'b0;
      dec.is_store  = 1'b0;
      dec.is_jump   = 1'b0;
      dec.illegal   = 1'b1;
      if (ILLEGAL_AS_NOP) begin
        dec.rs1 = '0;
        dec.rs2 = '0;
        dec.rd  = '0;
      end
    end
    if (dec.rd == 5'd0) dec.reg_we = 1'b0;
  end

  // ---------------- main + skid buffer ----------------
  bundle_t main_q, main_d, skid_q, skid_d;
  logic    main_vld_q, main_vld_d, skid_vld_q, skid_vld_d, rdy_q, rdy_d;
  logic    accept, main_free;

  // rdy_q always mirrors !skid_vld_q, so a skid->main move never coincides
  // with an accept.
  assign accept    = in_valid & rdy_q;
  assign main_free = ~main_vld_q | out_ready;

  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (main_free) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else begin
        main_vld_d = accept;
        if (accept) main_d = dec;
      end
    end else if (accept) begin
      skid_d     = dec;
      skid_vld_d = 1'b1;
    end
    rdy_d = ~skid_vld_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b1;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      rdy_q      <= rdy_d;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = main_vld_q;
  assign out_pc    = main_q.pc;
  assign alu_op    = main_q.alu_op;
  assign rs1       = main_q.rs1;
  assign rs2       = main_q.rs2;
  assign rd        = main_q.rd;
  assign imm       = main_q.imm;
  assign use_imm   = main_q.use_imm;
  assign use_pc    = main_q.use_pc;
  assign reg_we    = main_q.reg_we;
  assign is_branch = main_q.is_branch;
  assign br_invert = main_q.br_invert;
  assign is_load   = main_q.is_load;
  assign is_store  = main_q.is_store;
  assign is_jump   = main_q.is_jump;
  assign illegal   = main_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
module tb_alu_decode_stage;

  localparam logic [3:0] ADD = 0, SUB = 1, SLL = 2, SRL = 3, SRA = 4, OR_ = 5,
                         AND_ = 6, XOR_ = 7, SLT = 8, ULT = 9, UGTE = 10,
                         EQ = 11, SGTE = 12;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  op;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic use_imm, use_pc, reg_we, is_branch, br_invert, is_load, is_store, is_jump, illegal;
  } bun_t;

  logic        clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_instr = 0, in_pc = 0;
  logic        in_ready, out_valid;
  logic [31:0] out_pc, imm;
  logic [3:0]  alu_op;
  logic [4:0]  rs1, rs2, rd;
  logic use_imm, use_pc, reg_we, is_branch, br_invert, is_load, is_store, is_jump, illegal;

  alu_decode_stage #(.PC_W(32), .ILLEGAL_AS_NOP(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .alu_op(alu_op), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
    .use_imm(use_imm), .use_pc(use_pc), .reg_we(reg_we), .is_branch(is_branch),
    .br_invert(br_invert), .is_load(is_load), .is_store(is_store), .is_jump(is_jump),
    .illegal(illegal));

  always #5 clk = ~clk;

  bun_t obs;
  assign obs = {out_pc, alu_op, rs1, rs2, rd, imm, use_imm, use_pc, reg_we, is_branch,
                br_invert, is_load, is_store, is_jump, illegal};

  int   tests = 0, fails = 0;
  bun_t q[$];   // everything accepted and not yet drained, oldest first

  // Reference decoder: derived from the ISA tables, one instruction class at a time.
  function automatic bun_t ref_dec(input logic [31:0] w, input logic [31:0] pc);
    logic [3:0] alu_tab [8];
    logic [3:0] br_tab [8];
    bun_t b;
    logic [6:0] opc;
    int f3, f7;
    logic bad;
    alu_tab = '{ADD, SLL, SLT, ULT, XOR_, SRL, OR_, AND_};
    br_tab  = '{EQ, EQ, ADD, ADD, SLT, SGTE, ULT, UGTE};
    opc = w[6:0]; f3 = int'(w[14:12]); f7 = int'(w[31:25]);
    b = '0; b.pc = pc; b.rs1 = w[19:15]; b.rs2 = w[24:20]; b.rd = w[11:7];
    bad = 0;
    if (opc == 7'h33) begin
      b.reg_we = 1; b.op = alu_tab[f3];
      if (f7 == 32) begin
        if (f3 == 0) b.op = SUB; else if (f3 == 5) b.op = SRA; else bad = 1;
      end else if (f7 != 0) bad = 1;
    end else if (opc == 7'h13) begin
      b.reg_we = 1; b.use_imm = 1; b.op = alu_tab[f3];
      b.imm = 32'($signed(w) >>> 20);
      if (f3 == 1 || f3 == 5) begin
        b.imm = 32'(w[24:20]);
        if (f3 == 5 && f7 == 32) b.op = SRA; else if (f7 != 0) bad = 1;
      end
    end else if (opc == 7'h37 || opc == 7'h17) begin
      b.use_imm = 1; b.reg_we = 1; b.imm = w & 32'hFFFF_F000;
      if (opc == 7'h37) b.rs1 = 0; else b.use_pc = 1;
    end else if (opc == 7'h03) begin
      b.use_imm = 1; b.is_load = 1; b.reg_we = 1; b.imm = 32'($signed(w) >>> 20);
      bad = (f3 == 3 || f3 == 6 || f3 == 7);
    end else if (opc == 7'h23) begin
      b.use_imm = 1; b.is_store = 1;
      b.imm = (32'($signed(w) >>> 20) & ~32'h1F) | 32'(w[11:7]);
      bad = (f3 > 2);
    end else if (opc == 7'h63) begin
      b.is_branch = 1; b.op = br_tab[f3]; b.br_invert = (f3 == 1);
      b.imm = (32'($signed(w) >>> 19) & ~32'hFFF) | (32'(w[7]) << 11) |
              (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
      b.imm[12] = w[31];
      bad = (f3 == 2 || f3 == 3);
    end else if (opc == 7'h6F) begin
      b.use_pc = 1; b.use_imm = 1; b.is_jump = 1; b.reg_we = 1;
      b.imm = (32'($signed(w) >>> 11) & ~32'hF_FFFF) | (w & 32'h000F_F000) |
              (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
    end else if (opc == 7'h67) begin
      b.use_imm = 1; b.is_jump = 1; b.reg_we = 1; b.imm = 32'($signed(w) >>> 20);
      bad = (f3 != 0);
    end else bad = 1;
    if (bad) begin
      b.op = ADD; b.imm = 0; b.use_imm = 0; b.use_pc = 0; b.reg_we = 0; b.is_branch = 0;
      b.br_invert = 0; b.is_load = 0; b.is_store = 0; b.is_jump = 0; b.illegal = 1;
    end
    if (b.rd == 0) b.reg_we = 0;
    return b;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [6:0] opcs [9];
    logic [31:0] w;
    int k;
    opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67};
    w = $urandom;
    k = $urandom_range(0, 10);
    if (k < 9) w[6:0] = opcs[k];
    if (k < 2) begin
      case ($urandom_range(0, 3))
        0: w[31:25] = 7'h00;
        1: w[31:25] = 7'h20;
        default: ;
      endcase
    end
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // One clock: drive inputs, compare against the model at the negedge,
  // then advance the model by the handshakes of this cycle.
  task automatic step(input logic v, input logic [31:0] w, input logic [31:0] pc,
                      input logic ordy, input logic fl, input string tag);
    logic fire, drain;
    in_valid = v; in_instr = w; in_pc = pc; out_ready = ordy; flush = fl;
    @(negedge clk);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() != 0));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(q.size() < 2));
    if (q.size() != 0) begin
      tests++;
      assert (obs === q[0]) else begin
        fails++;
        $error("FAIL %s.bundle observed=%h expected=%h", tag, obs, q[0]);
      end
    end
    fire  = v && (q.size() < 2);
    drain = ordy && (q.size() != 0);
    @(posedge clk); #1;
    if (fl) q.delete();
    else begin
      if (drain) void'(q.pop_front());
      if (fire) q.push_back(ref_dec(w, pc));
    end
  endtask

  initial begin
    logic [31:0] wv [4];
    // ---- reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_valid", 32'(out_valid), 0);
    chk("rst.in_ready", 32'(in_ready), 1);
    chk("rst.bundle_lo", obs[31:0], 0);
    chk("rst.out_pc", out_pc, 0);
    rst_n = 1;

    // ---- directed decodes
    step(1, 32'h00500093, 32'h100, 1, 0, "addi");
    chk("addi.valid", 32'(out_valid), 1);
    chk("addi.op", 32'(alu_op), 32'(ADD));
    chk("addi.rd", 32'(rd), 1);
    chk("addi.rs1", 32'(rs1), 0);
    chk("addi.imm", imm, 5);
    chk("addi.use_imm", 32'(use_imm), 1);
    chk("addi.reg_we", 32'(reg_we), 1);
    step(1, 32'h402081B3, 32'h104, 1, 0, "sub");
    chk("sub.op", 32'(alu_op), 32'(SUB));
    chk("sub.regs", {17'd0, rs1, rs2, rd}, {17'd0, 5'd1, 5'd2, 5'd3});
    chk("sub.use_imm", 32'(use_imm), 0);
    step(1, 32'h40335293, 32'h108, 1, 0, "srai");
    chk("srai.op", 32'(alu_op), 32'(SRA));
    chk("srai.shamt", 32'(imm[4:0]), 3);
    step(1, 32'h00208463, 32'h10C, 1, 0, "beq");
    chk("beq.op", 32'(alu_op), 32'(EQ));
    chk("beq.flags", {28'd0, is_branch, reg_we, br_invert, 1'b0}, 32'b1000);
    chk("beq.imm", imm, 8);
    step(1, 32'h00209463, 32'h110, 1, 0, "bne");
    chk("bne.br_invert", 32'(br_invert), 1);
    step(0, 0, 0, 1, 0, "drain");

    // ---- back-pressure: fill main+skid, extra words refused, then in-order drain
    for (int i = 0; i < 4; i++) wv[i] = gen_instr();
    step(1, wv[0], 32'h200, 0, 0, "bp0");
    step(1, wv[1], 32'h204, 0, 0, "bp1");
    chk("bp.in_ready_full", 32'(in_ready), 0);
    step(1, wv[2], 32'h208, 0, 0, "bp2a");
    step(1, wv[2], 32'h208, 0, 0, "bp2b");
    step(1, wv[2], 32'h208, 1, 0, "bp2c");
    step(1, wv[2], 32'h208, 1, 0, "bp2d");
    step(1, wv[3], 32'h20C, 1, 0, "bp3");
    step(0, 0, 0, 1, 0, "bpd0");
    step(0, 0, 0, 1, 0, "bpd1");
    step(0, 0, 0, 1, 0, "bpd2");

    // ---- flush with both entries full, then with a same-cycle accept
    step(1, 32'h00100113, 32'h300, 0, 0, "fl0");
    step(1, 32'h00200193, 32'h304, 0, 0, "fl1");
    step(1, 32'h00300213, 32'h308, 0, 1, "fl2");
    chk("flush.out_valid", 32'(out_valid), 0);
    chk("flush.in_ready", 32'(in_ready), 1);
    step(1, 32'h00400293, 32'h30C, 0, 0, "fl3");
    step(1, 32'h00500313, 32'h310, 0, 1, "fl4");
    chk("flush2.out_valid", 32'(out_valid), 0);
    step(1, 32'hFFFFFFFF, 32'h314, 1, 0, "ill");
    chk("ill.illegal", 32'(illegal), 1);
    chk("ill.reg_we", 32'(reg_we), 0);
    chk("ill.op", 32'(alu_op), 32'(ADD));
    step(0, 0, 0, 1, 0, "illd");

    // ---- reset mid-stream
    step(1, gen_instr(), 32'h400, 0, 0, "rs0");
    step(1, gen_instr(), 32'h404, 0, 0, "rs1");
    rst_n = 0; in_valid = 0; #1;
    chk("midrst.out_valid", 32'(out_valid), 0);
    chk("midrst.in_ready", 32'(in_ready), 1);
    q.delete();
    #2 rst_n = 1;
    @(posedge clk); #1;
    step(0, 0, 0, 1, 0, "postrst");

    // ---- randomized traffic against the model
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 9) < 7, gen_instr(), $urandom, $urandom_range(0, 9) < 6,
           $urandom_range(0, 99) < 3, "rnd");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, "final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
